// File: rtl/slot_pkg.sv
// Shared definitions for the slot machine: game-state encoding seen by the
// reel stage, credit widths and the saturating credit helper.
package slot_pkg;

  // Credit counter width; the top clamps to a ceiling that fits in it.
  localparam int CREDIT_W = 8;

  // Game state encoding. The reel stage decodes RUN = 2'b10 directly,
  // so these values must not change.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ARM    = 2'b01;
  localparam logic [1:0] ST_RUN    = 2'b10;
  localparam logic [1:0] ST_RESULT = 2'b11;

  typedef logic [CREDIT_W-1:0] credit_t;
  // One extra bit so old + coin + payout cannot wrap before clamping.
  typedef logic [CREDIT_W:0]   credit_sum_t;

  // Clamp a widened credit sum to the configured ceiling.
  function automatic credit_t credit_clamp(input credit_sum_t sum,
                                           input credit_t     max_c);
    if (sum > {1'b0, max_c}) begin
      return max_c;
    end
    return sum[CREDIT_W-1:0];
  endfunction

endpackage

// File: rtl/key_edge.sv
// Raw DE1 key conditioner: 2-flop synchroniser, registered falling-edge
// press pulse and the synchronised level (used for release detection).
// The press pulse is high for one cycle, three cycles after the pin falls.
module key_edge
  import slot_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_ni,   // raw key, active-low, asynchronous
  output logic press_o,  // one-cycle pulse per press
  output logic level_o   // synchronised key level (1 = released)
);

  logic [1:0] sync_q;    // [0] first stage, [1] second stage
  logic       prev_q;    // previous synchronised level
  logic       press_q;

  // Synchronise the key, remember the last level and register the press edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the synchroniser resets to the released level (1); resetting it
      // to 0 would fake a press-and-release and could start a spin at reset.
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the value its
      // predecessor had before the edge; blocking here would collapse the chain.
      sync_q  <= {sync_q[0], key_ni};
      prev_q  <= sync_q[1];
      press_q <= prev_q & ~sync_q[1];
    end
  end

  assign press_o = press_q;
  assign level_o = sync_q[1];

endmodule

// File: rtl/slot_game_ctrl.sv
// Slot machine game controller. Owns the credit counter, turns key presses
// into coin/spin events and sequences IDLE -> ARM -> RUN -> RESULT for the
// downstream reel stage, with a watchdog in RUN and a timed RESULT display.
module slot_game_ctrl
  import slot_pkg::*;
#(
  parameter int unsigned INIT_CREDITS = 10,
  parameter int unsigned BET          = 1,
  parameter int unsigned PAYOUT       = 20,
  parameter int unsigned MAX_CREDITS  = 255,          // must be <= 255
  parameter int unsigned RESULT_HOLD  = 100_000_000,  // 2 s at 50 MHz
  parameter int unsigned RUN_TIMEOUT  = 200_000_000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                btn_spin_ni,
  input  logic                btn_coin_ni,
  input  logic                done_i,
  input  logic                win_i,
  output logic [1:0]          state_o,
  output logic [CREDIT_W-1:0] credits_o,
  output logic                win_led_o,
  output logic                no_credit_o,
  output logic                timeout_o
);

  // One counter serves as RUN watchdog and RESULT hold timer, so it is sized
  // for the larger of the two limits.
  localparam int unsigned CNT_MAX = (RESULT_HOLD > RUN_TIMEOUT) ? RESULT_HOLD : RUN_TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESULT_HOLD - 1);

  localparam credit_t     CREDIT_INIT = credit_t'(INIT_CREDITS);
  localparam credit_t     CREDIT_MAX  = credit_t'(MAX_CREDITS);
  localparam credit_t     BET_C       = credit_t'(BET);
  localparam credit_sum_t BET_W       = credit_sum_t'(BET);
  localparam credit_sum_t PAY_W       = credit_sum_t'(PAYOUT);

  // ---------------------------------------------------------------------------
  // Key conditioning
  // ---------------------------------------------------------------------------
  logic spin_press;
  logic spin_level;
  logic coin_press;
  logic coin_level_unused;  // coin needs no release tracking

  key_edge u_spin_key (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .key_ni  (btn_spin_ni),
    .press_o (spin_press),
    .level_o (spin_level)
  );

  key_edge u_coin_key (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .key_ni  (btn_coin_ni),
    .press_o (coin_press),
    .level_o (coin_level_unused)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  credit_t          credits_q, credits_d;
  logic             win_led_q, win_led_d;
  logic             timeout_q, timeout_d;

  logic             take_bet;
  logic             take_pay;
  credit_sum_t      credit_sum;

  // Next-state logic for the game sequence and the credit adjustments.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    win_led_d = win_led_q;
    timeout_d = timeout_q;
    take_bet  = 1'b0;
    take_pay  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Affordability is judged on the credits before any same-cycle coin.
        if (spin_press && (credits_q >= BET_C)) begin
          take_bet  = 1'b1;
          win_led_d = 1'b0;
          timeout_d = 1'b0;
          state_d   = ST_ARM;
        end
      end

      ST_ARM: begin
        // Wait for the key to be released so a held key cannot re-trigger.
        cnt_d = '0;
        if (spin_level) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // done_i takes priority over a watchdog expiry on the same cycle.
        if (done_i) begin
          state_d = ST_RESULT;
          cnt_d   = '0;
        end else if (cnt_q == RUN_LAST) begin
          state_d   = ST_RESULT;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end

      default: begin  // ST_RESULT
        // win_i is only valid on the first RESULT cycle; a timed-out spin
        // never pays regardless of what the reel stage reports.
        if ((cnt_q == '0) && win_i && !timeout_q) begin
          win_led_d = 1'b1;
          take_pay  = 1'b1;
        end
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
    endcase

    // Coin, payout and bet all land in one widened sum, then clamp.
    credit_sum = {1'b0, credits_q}
               + credit_sum_t'(coin_press)
               + (take_pay ? PAY_W : '0)
               - (take_bet ? BET_W : '0);
    credits_d  = credit_clamp(credit_sum, CREDIT_MAX);
  end

  // Register the game state; reset aborts any spin without refund or payout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      credits_q <= CREDIT_INIT;
      win_led_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      credits_q <= credits_d;
      win_led_q <= win_led_d;
      timeout_q <= timeout_d;
    end
  end

  assign state_o     = state_q;
  assign credits_o   = credits_q;
  assign win_led_o   = win_led_q;
  assign timeout_o   = timeout_q;
  assign no_credit_o = (credits_q < BET_C);

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Self-checking bench for slot_game_ctrl. The reel stage and the player are
// modelled by tasks; expected credits and flags come from a transaction-level
// model using plain integer arithmetic.
module tb_slot_game_ctrl;
  import slot_pkg::*;

  localparam int HOLD = 8;
  localparam int TMO  = 50;
  localparam int INIT = 2;
  localparam int BET  = 1;
  localparam int PAY  = 20;
  localparam int MAXC = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spin_n = 1'b1;
  logic       coin_n = 1'b1;
  logic       done = 1'b0;
  logic       win = 1'b0;
  logic [1:0] state;
  logic [7:0] credits;
  logic       win_led;
  logic       no_credit;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int exp_credits;
  bit exp_win_led;
  bit exp_timeout;

  always #5 clk = ~clk;

  slot_game_ctrl #(
    .INIT_CREDITS (INIT),
    .BET          (BET),
    .PAYOUT       (PAY),
    .MAX_CREDITS  (MAXC),
    .RESULT_HOLD  (HOLD),
    .RUN_TIMEOUT  (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .btn_spin_ni (spin_n),
    .btn_coin_ni (coin_n),
    .done_i      (done),
    .win_i       (win),
    .state_o     (state),
    .credits_o   (credits),
    .win_led_o   (win_led),
    .no_credit_o (no_credit),
    .timeout_o   (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic check_outputs(input string tag, input logic [1:0] exp_state);
    check({tag, "/state"},     state,     exp_state);
    check({tag, "/credits"},   credits,   exp_credits);
    check({tag, "/win_led"},   win_led,   exp_win_led);
    check({tag, "/timeout"},   timeout,   exp_timeout);
    check({tag, "/no_credit"}, no_credit, (exp_credits < BET) ? 1 : 0);
  endtask

  task automatic model_reset();
    exp_credits = INIT;
    exp_win_led = 1'b0;
    exp_timeout = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    model_reset();
    check_outputs("reset", ST_IDLE);
    rst = 1'b0;
  endtask

  task automatic coin();
    coin_n = 1'b0;
    repeat (2) tick();
    coin_n = 1'b1;
    repeat (4) tick();
    exp_credits = clamp(exp_credits + 1);
    check_outputs("coin", ST_IDLE);
  endtask

  // One spin. run_len = 0 lets the watchdog fire, otherwise done_i rises after
  // run_len RUN cycles. coin_late lands a coin pulse on the RESULT-entry cycle.
  task automatic spin(input int run_len, input bit do_win, input bit coin_late, input bit abort);
    int c0;
    int n;
    c0 = exp_credits;
    spin_n = 1'b0;
    repeat (4) tick();
    if (c0 < BET) begin
      check_outputs("spin_broke", ST_IDLE);
      spin_n = 1'b1;
      repeat (4) tick();
      check_outputs("spin_broke_rel", ST_IDLE);
      return;
    end
    exp_credits = c0 - BET;
    exp_win_led = 1'b0;
    exp_timeout = 1'b0;
    check_outputs("arm", ST_ARM);
    repeat ($urandom_range(0, 3)) tick();
    check("arm_held", state, ST_ARM);

    spin_n = 1'b1;
    n = 0;
    while (state != ST_RUN && n < 8) begin
      tick();
      n++;
    end
    check("run_reached", state, ST_RUN);
    check("release_latency_le3", (n <= 3) ? 1 : 0, 1);
    if (state != ST_RUN) return;

    if (abort) begin
      repeat ($urandom_range(1, 10)) tick();
      rst = 1'b1;
      tick();
      model_reset();
      check_outputs("abort", ST_IDLE);
      rst = 1'b0;
      return;
    end

    if (run_len == 0) begin
      repeat (TMO - 1) tick();
      check("wd_still_run", state, ST_RUN);
      tick();
      exp_timeout = 1'b1;
      check_outputs("wd_result", ST_RESULT);
      // Reel stage claims a win and the player mashes spin: both ignored.
      win = 1'b1;
      spin_n = 1'b0;
      tick();
      win = 1'b0;
      check_outputs("wd_win_ignored", ST_RESULT);
      tick();
      spin_n = 1'b1;
      repeat (HOLD - 3) tick();
      check_outputs("wd_hold", ST_RESULT);
      tick();
      check_outputs("wd_idle", ST_IDLE);
    end else begin
      for (int i = 0; i < run_len; i++) begin
        if (coin_late && i == run_len - 2) coin_n = 1'b0;
        tick();
      end
      check("run_before_done", state, ST_RUN);
      done = 1'b1;
      tick();
      check_outputs("result_entry", ST_RESULT);
      win = do_win;
      tick();
      win = 1'b0;
      done = 1'b0;
      coin_n = 1'b1;
      exp_credits = clamp(exp_credits + (coin_late ? 1 : 0) + (do_win ? PAY : 0));
      exp_win_led = do_win;
      check_outputs("result_pay", ST_RESULT);
      repeat (HOLD - 2) tick();
      check("result_hold", state, ST_RESULT);
      tick();
      check_outputs("back_idle", ST_IDLE);
    end
  endtask

  initial begin
    #800_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int op;
    rst = 1'b1;
    repeat (3) tick();
    model_reset();
    check_outputs("por", ST_IDLE);
    rst = 1'b0;
    tick();
    check_outputs("por_release", ST_IDLE);

    // Winning spin from 2 credits: 2 -> 1 -> 21, LED persists into IDLE.
    spin(10, 1'b1, 1'b0, 1'b0);

    // Drain to zero: losing spin then a watchdog spin.
    do_reset();
    spin(3, 1'b0, 1'b0, 1'b0);
    spin(0, 1'b0, 1'b0, 1'b0);
    spin(5, 1'b1, 1'b0, 1'b0);   // unaffordable, ignored
    coin();

    // done_i on the exact watchdog cycle: done wins, the win pays.
    spin(TMO - 1, 1'b1, 1'b0, 1'b0);

    // Saturation: 250 credits, win plus coin on RESULT entry -> 255.
    while (exp_credits < 250) coin();
    spin(6, 1'b1, 1'b1, 1'b0);
    coin();

    // Reset mid-RUN.
    spin(0, 1'b0, 1'b0, 1'b1);

    // Randomised sequence of player/reel events.
    repeat (30) begin
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        coin();
      end else if (op == 3) begin
        spin(0, 1'b0, 1'b0, 1'b1);
      end else if (op == 4) begin
        spin(0, 1'b0, 1'b0, 1'b0);
      end else begin
        spin($urandom_range(2, TMO - 1), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
